// File: rtl/m68k_decode_pkg.sv
// ----------------------------------------------------------------------------
// m68k_decode_pkg
// Shared types and constants for the table-driven 68000 region decoder.
//   ADDR_W_DEF  : default CPU address width (also sizes the stored region base)
//   WS_W_DEF    : default wait-state count width (also sizes the stored ws)
//   region_cfg_t: one decode table entry {base, width, ws, en}
//   dec_state_t : bus-cycle state machine states
//   idx_width() : width of a region index, never less than 1
// ----------------------------------------------------------------------------
package m68k_decode_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int WS_W_DEF   = 3;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] base;
    logic [4:0]            width;
    logic [WS_W_DEF-1:0]   ws;
    logic                  en;
  } region_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } dec_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m68k_region_decoder_if.sv
// ----------------------------------------------------------------------------
// m68k_region_decoder_if
// Bus bundle between the 68000 side (CPU strobe/address plus the boot-time
// region-table loader) and the region decoder.
//   master : drives cpu_a, cpu_as_n, cfg_* ; observes cs, hit_idx, hit,
//            dtack_n, berr_n
//   slave  : the decoder (mirror of master)
// Parameters must match those of the decoder instance.
// ----------------------------------------------------------------------------
interface m68k_region_decoder_if
  import m68k_decode_pkg::*;
#(
  parameter int NUM_REGIONS = 24,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WS_W        = WS_W_DEF
);

  localparam int IDX_W = idx_width(NUM_REGIONS);

  // CPU side
  logic [ADDR_W-1:0]      cpu_a;
  logic                   cpu_as_n;

  // Region table loader
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic [ADDR_W-1:0]      cfg_base;
  logic [4:0]             cfg_width;
  logic [WS_W-1:0]        cfg_ws;
  logic                   cfg_en;

  // Decoder outputs
  logic [NUM_REGIONS-1:0] cs;
  logic [IDX_W-1:0]       hit_idx;
  logic                   hit;
  logic                   dtack_n;
  logic                   berr_n;

  modport master (
    output cpu_a, cpu_as_n,
    output cfg_we, cfg_idx, cfg_base, cfg_width, cfg_ws, cfg_en,
    input  cs, hit_idx, hit, dtack_n, berr_n
  );

  modport slave (
    input  cpu_a, cpu_as_n,
    input  cfg_we, cfg_idx, cfg_base, cfg_width, cfg_ws, cfg_en,
    output cs, hit_idx, hit, dtack_n, berr_n
  );

endinterface

// File: rtl/region_match.sv
// ----------------------------------------------------------------------------
// region_match
// Combinational compare of one decode region against the CPU address.
//   addr  : CPU byte address
//   base  : region base address
//   width : number of low address bits ignored in the compare
//   en    : region enable
//   match : region enabled and addr/base agree above bit 'width'
// ----------------------------------------------------------------------------
module region_match
  import m68k_decode_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        width,
  input  logic              en,
  output logic              match
);

  // (addr >> width) == (base >> width) expressed as a masked XOR so no
  // shifter is needed on the address path.
  logic [ADDR_W-1:0] mask;

  assign mask  = {ADDR_W{1'b1}} << width;
  assign match = en && (((addr ^ base) & mask) == '0);

endmodule

// File: rtl/m68k_region_decoder.sv
// ----------------------------------------------------------------------------
// m68k_region_decoder
// Table-driven 68000 address decoder with registered one-hot chip selects and
// per-region DTACK wait-state generation. The region table is written at boot
// by the pcb-id ROM loader through the cfg_* signals.
//
// Ports:
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset (clears FSM, outputs and table)
//   bus     : m68k_region_decoder_if.slave
//             cpu_a/cpu_as_n  CPU address and strobe (sampled on clk_sys)
//             cfg_*           region table write port (1-cycle writes)
//             cs/hit/hit_idx  registered decode result of the latched cycle
//             dtack_n/berr_n  registered bus acknowledge / bus error
//
// Optional feature: define M68K_DECODE_BERR_EN to turn unmapped accesses into
// a bus error after BERR_CYCLES cycles. Without it berr_n is tied high and
// unmapped accesses get a zero-wait-state dtack_n (open bus).
// ----------------------------------------------------------------------------
module m68k_region_decoder
  import m68k_decode_pkg::*;
#(
  parameter int NUM_REGIONS = 24,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WS_W        = WS_W_DEF,
  parameter int BERR_CYCLES = 64
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  m68k_region_decoder_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_REGIONS);

  // Region table
  region_cfg_t cfg_tab_q [NUM_REGIONS];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cfg_tab_q[i] <= '0;
      end
    end else if (bus.cfg_we && (32'(bus.cfg_idx) < NUM_REGIONS)) begin
      cfg_tab_q[bus.cfg_idx] <= '{base:  ADDR_W_DEF'(bus.cfg_base),
                                  width: bus.cfg_width,
                                  ws:    WS_W_DEF'(bus.cfg_ws),
                                  en:    bus.cfg_en};
    end
  end

  // ---- stage p0: combinational match and priority encode ----
  logic [NUM_REGIONS-1:0] match_p0;
  logic [IDX_W-1:0]       win_idx_p0;
  logic                   win_hit_p0;
  logic [WS_W-1:0]        win_ws_p0;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    region_match #(
      .ADDR_W (ADDR_W)
    ) u_region_match (
      .addr  (bus.cpu_a),
      .base  (ADDR_W'(cfg_tab_q[g].base)),
      .width (cfg_tab_q[g].width),
      .en    (cfg_tab_q[g].en),
      .match (match_p0[g])
    );
  end

  // Lowest index wins when regions overlap.
  function automatic logic [IDX_W-1:0] first_hit(input logic [NUM_REGIONS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign win_idx_p0 = first_hit(match_p0);
  assign win_hit_p0 = |match_p0;
  assign win_ws_p0  = WS_W'(cfg_tab_q[win_idx_p0].ws);

  // ---- stage p1: bus-cycle FSM with registered outputs ----
  dec_state_t             state_p1;
  logic [WS_W-1:0]        ws_cnt_p1;
  logic [NUM_REGIONS-1:0] cs_p1;
  logic [IDX_W-1:0]       hit_idx_p1;
  logic                   hit_p1;
  logic                   dtack_n_p1;

`ifdef M68K_DECODE_BERR_EN
  localparam int BERR_W = $clog2(BERR_CYCLES + 1);
  logic [BERR_W-1:0]      berr_cnt_p1;
  logic                   berr_n_p1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_p1    <= IDLE;
      ws_cnt_p1   <= '0;
      cs_p1       <= '0;
      hit_idx_p1  <= '0;
      hit_p1      <= 1'b0;
      dtack_n_p1  <= 1'b1;
`ifdef M68K_DECODE_BERR_EN
      berr_cnt_p1 <= '0;
      berr_n_p1   <= 1'b1;
`endif
    end else begin
      case (state_p1)
        IDLE: begin
          // The address is decoded once here; later cpu_a changes while the
          // strobe is held do not disturb the latched region.
          if (!bus.cpu_as_n) begin
            state_p1 <= WAIT;
            hit_p1   <= win_hit_p0;
`ifdef M68K_DECODE_BERR_EN
            berr_cnt_p1 <= '0;
`endif
            if (win_hit_p0) begin
              cs_p1      <= NUM_REGIONS'(1) << win_idx_p0;
              hit_idx_p1 <= win_idx_p0;
              ws_cnt_p1  <= win_ws_p0;
            end else begin
              cs_p1      <= '0;
              hit_idx_p1 <= '0;
              ws_cnt_p1  <= '0;
            end
          end
        end

        WAIT: begin
          if (bus.cpu_as_n) begin
            // Aborted cycle: drop everything, no acknowledge.
            state_p1   <= IDLE;
            cs_p1      <= '0;
            hit_p1     <= 1'b0;
            hit_idx_p1 <= '0;
            ws_cnt_p1  <= '0;
          end
`ifdef M68K_DECODE_BERR_EN
          else if (!hit_p1) begin
            if (berr_cnt_p1 == BERR_W'(BERR_CYCLES - 1)) begin
              berr_n_p1 <= 1'b0;
              state_p1  <= ACK;
            end else begin
              berr_cnt_p1 <= berr_cnt_p1 + BERR_W'(1);
            end
          end
`endif
          else if (ws_cnt_p1 == '0) begin
            dtack_n_p1 <= 1'b0;
            state_p1   <= ACK;
          end else begin
            ws_cnt_p1 <= ws_cnt_p1 - WS_W'(1);
          end
        end

        ACK: begin
          if (bus.cpu_as_n) begin
            state_p1   <= IDLE;
            cs_p1      <= '0;
            hit_p1     <= 1'b0;
            hit_idx_p1 <= '0;
            dtack_n_p1 <= 1'b1;
`ifdef M68K_DECODE_BERR_EN
            berr_n_p1  <= 1'b1;
`endif
          end
        end

        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign bus.cs      = cs_p1;
  assign bus.hit_idx = hit_idx_p1;
  assign bus.hit     = hit_p1;
  assign bus.dtack_n = dtack_n_p1;
`ifdef M68K_DECODE_BERR_EN
  assign bus.berr_n  = berr_n_p1;
`else
  assign bus.berr_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_region_decoder.sv
// ----------------------------------------------------------------------------
// tb_m68k_region_decoder
// Directed-vector bench for m68k_region_decoder. Inputs are driven 1 ns after
// the rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_m68k_region_decoder;

  localparam int NUM_REGIONS = 24;
  localparam int ADDR_W      = 24;
  localparam int WS_W        = 3;

  logic clk_sys;
  logic reset_n;

  int checks;
  int errors;

  m68k_region_decoder_if #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .WS_W        (WS_W)
  ) bus ();

  m68k_region_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .WS_W        (WS_W),
    .BERR_CYCLES (64)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic cfg_write(input int idx, input logic [23:0] base, input int w,
                           input int ws, input logic en);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 5'(idx);
    bus.cfg_base  = base;
    bus.cfg_width = 5'(w);
    bus.cfg_ws    = 3'(ws);
    bus.cfg_en    = en;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic strobe(input logic [23:0] a);
    bus.cpu_a    = a;
    bus.cpu_as_n = 1'b0;
  endtask

  task automatic release_as();
    bus.cpu_as_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n       = 1'b0;
    bus.cpu_a     = '0;
    bus.cpu_as_n  = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_base  = '0;
    bus.cfg_width = '0;
    bus.cfg_ws    = '0;
    bus.cfg_en    = 1'b0;

    // Reset state
    tick(3);
    chk("rst_cs",      32'(bus.cs), 32'h0);
    chk("rst_hit",     32'(bus.hit), 32'h0);
    chk("rst_hit_idx", 32'(bus.hit_idx), 32'h0);
    chk("rst_dtack",   32'(bus.dtack_n), 32'h1);
    chk("rst_berr",    32'(bus.berr_n), 32'h1);
    reset_n = 1'b1;
    tick();

    // Region 1 with 2 wait states
    cfg_write(0, 24'h000000, 19, 0, 1'b1);
    cfg_write(1, 24'h080000, 15, 2, 1'b1);
    strobe(24'h080010);
    tick();
    chk("r1_cs",      32'(bus.cs), 32'h0000_0002);
    chk("r1_hit",     32'(bus.hit), 32'h1);
    chk("r1_hit_idx", 32'(bus.hit_idx), 32'h1);
    chk("r1_dtack_c0", 32'(bus.dtack_n), 32'h1);
    bus.cpu_a = 24'h000000;               // must not re-decode to region 0
    tick();
    chk("r1_dtack_c1", 32'(bus.dtack_n), 32'h1);
    tick();
    chk("r1_dtack_c2", 32'(bus.dtack_n), 32'h1);
    chk("r1_cs_held",  32'(bus.cs), 32'h0000_0002);
    tick();
    chk("r1_dtack_c3", 32'(bus.dtack_n), 32'h0);
    tick();
    chk("r1_ack_hold", 32'(bus.dtack_n), 32'h0);
    release_as();
    tick();
    chk("r1_rel_cs",    32'(bus.cs), 32'h0);
    chk("r1_rel_dtack", 32'(bus.dtack_n), 32'h1);
    chk("r1_rel_hit",   32'(bus.hit), 32'h0);
    tick();

    // Overlap: lowest index wins
    cfg_write(2, 24'h400000, 1, 0, 1'b1);
    cfg_write(5, 24'h400000, 12, 0, 1'b1);
    strobe(24'h400000);
    tick();
    chk("ovl_cs",      32'(bus.cs), 32'h0000_0004);
    chk("ovl_hit_idx", 32'(bus.hit_idx), 32'h2);
    tick();
    chk("ovl_dtack", 32'(bus.dtack_n), 32'h0);
    release_as();
    tick(2);

    // Unmapped access
    strobe(24'h700000);
    tick();
    chk("unm_cs",    32'(bus.cs), 32'h0);
    chk("unm_hit",   32'(bus.hit), 32'h0);
    chk("unm_dtack0", 32'(bus.dtack_n), 32'h1);
`ifdef M68K_DECODE_BERR_EN
    tick(63);
    chk("unm_berr_63", 32'(bus.berr_n), 32'h1);
    tick();
    chk("unm_berr_64", 32'(bus.berr_n), 32'h0);
    chk("unm_dtack_be", 32'(bus.dtack_n), 32'h1);
    release_as();
    tick();
    chk("unm_berr_rel", 32'(bus.berr_n), 32'h1);
`else
    tick();
    chk("unm_dtack1", 32'(bus.dtack_n), 32'h0);
    chk("unm_berr",   32'(bus.berr_n), 32'h1);
    release_as();
    tick();
    chk("unm_rel_dtack", 32'(bus.dtack_n), 32'h1);
`endif
    tick();

    // Aborted cycle in WAIT (ws 7)
    cfg_write(3, 24'h200000, 4, 7, 1'b1);
    strobe(24'h200000);
    tick();
    chk("abt_cs", 32'(bus.cs), 32'h0000_0008);
    tick(3);
    chk("abt_dtack_w", 32'(bus.dtack_n), 32'h1);
    release_as();
    tick();
    chk("abt_cs_clr",  32'(bus.cs), 32'h0);
    chk("abt_hit_clr", 32'(bus.hit), 32'h0);
    chk("abt_dtack",   32'(bus.dtack_n), 32'h1);
    tick(8);
    chk("abt_dtack_late", 32'(bus.dtack_n), 32'h1);

    // Config write during ACK does not disturb the latched cycle
    strobe(24'h080000);
    tick(4);
    chk("cwa_dtack", 32'(bus.dtack_n), 32'h0);
    cfg_write(1, 24'h080000, 15, 2, 1'b0);
    chk("cwa_cs_held",    32'(bus.cs), 32'h0000_0002);
    chk("cwa_dtack_held", 32'(bus.dtack_n), 32'h0);
    release_as();
    tick();
    chk("cwa_rel_cs", 32'(bus.cs), 32'h0);
    tick();
    strobe(24'h080000);
    tick();
    chk("cwa_next_hit", 32'(bus.hit), 32'h0);
    chk("cwa_next_cs",  32'(bus.cs), 32'h0);
    release_as();
    tick(2);

    // Config write and strobe in the same cycle: pre-write table is used
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 5'd6;
    bus.cfg_base  = 24'h600000;
    bus.cfg_width = 5'd4;
    bus.cfg_ws    = 3'd0;
    bus.cfg_en    = 1'b1;
    strobe(24'h600000);
    tick();
    bus.cfg_we = 1'b0;
    chk("same_hit", 32'(bus.hit), 32'h0);
    chk("same_cs",  32'(bus.cs), 32'h0);
    release_as();
    tick(2);
    strobe(24'h600000);
    tick();
    chk("same_next_cs",  32'(bus.cs), 32'h0000_0040);
    chk("same_next_idx", 32'(bus.hit_idx), 32'h6);
    release_as();
    tick(2);

    // Asynchronous reset in ACK
    strobe(24'h000100);
    tick();
    chk("ar_cs", 32'(bus.cs), 32'h0000_0001);
    tick();
    chk("ar_dtack", 32'(bus.dtack_n), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_rst_cs",      32'(bus.cs), 32'h0);
    chk("ar_rst_hit",     32'(bus.hit), 32'h0);
    chk("ar_rst_hit_idx", 32'(bus.hit_idx), 32'h0);
    chk("ar_rst_dtack",   32'(bus.dtack_n), 32'h1);
    chk("ar_rst_berr",    32'(bus.berr_n), 32'h1);
    #2;
    reset_n = 1'b1;
    release_as();
    tick(2);
    strobe(24'h000100);
    tick();
    chk("ar_after_hit", 32'(bus.hit), 32'h0);
    chk("ar_after_cs",  32'(bus.cs), 32'h0);
    release_as();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
